// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for a 1-bit ALU cell: feeds operand bits LSB first,
// recirculates the cell carry and collects the cell result into a WIDTH-bit word.
//
// state | meaning
// IDLE  | waiting for start; cell inputs held at 0
// RUN   | one operand bit pair per cycle presented to the cell
// DONE  | one-cycle done pulse, result and flags valid
module alu_serial_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             arit,
   input  logic [1:0]       s,
   input  logic             c_in,
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_arit,
   output logic             cell_cin,
   output logic [1:0]       cell_s,
   input  logic             cell_out,
   input  logic             cell_cout,
   output logic [WIDTH-1:0] result,
   output logic             c_flag,
   output logic             z_flag,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic             op_arit;
   logic [1:0]       op_s;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             in_run;

   assign in_run    = (state == RUN);
   assign shreg_nxt = {cell_out, shreg[WIDTH-1:1]};

   assign cell_a    = in_run & a_sh[0];
   assign cell_b    = in_run & b_sh[0];
   assign cell_cin  = in_run & carry;
   assign cell_arit = in_run & op_arit;
   assign cell_s    = in_run ? op_s : 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         shreg   <= '0;
         op_arit <= 1'b0;
         op_s    <= 2'b00;
         carry   <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         c_flag  <= 1'b0;
         z_flag  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  op_arit <= arit;
                  op_s    <= s;
                  carry   <= c_in;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               shreg <= shreg_nxt;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= cell_cout;
               cnt   <= cnt + CW'(1);
               // Last bit: capture the word including this cycle's cell output
               if (cnt == CW'(WIDTH - 1)) begin
                  result <= shreg_nxt;
                  c_flag <= op_arit & cell_cout;
                  z_flag <= ~|shreg_nxt;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq with a behavioural 1-bit cell closing the loop.
// Cell logic functions: s=00 AND, 01 OR, 10 XOR, 11 NAND.
module tb_alu_serial_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         arit;
   logic [1:0]   s;
   logic         c_in;
   logic         cell_a, cell_b, cell_arit, cell_cin;
   logic [1:0]   cell_s;
   logic         cell_out, cell_cout;
   logic [W-1:0] result;
   logic         c_flag, z_flag, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
      .arit(arit), .s(s), .c_in(c_in),
      .cell_a(cell_a), .cell_b(cell_b), .cell_arit(cell_arit),
      .cell_cin(cell_cin), .cell_s(cell_s),
      .cell_out(cell_out), .cell_cout(cell_cout),
      .result(result), .c_flag(c_flag), .z_flag(z_flag),
      .busy(busy), .done(done)
   );

   logic cell_logic;
   always_comb begin
      cell_logic = 1'b0;
      case (cell_s)
         2'b00: cell_logic = cell_a & cell_b;
         2'b01: cell_logic = cell_a | cell_b;
         2'b10: cell_logic = cell_a ^ cell_b;
         2'b11: cell_logic = ~(cell_a & cell_b);
         default: cell_logic = 1'b0;
      endcase
   end
   assign cell_out  = cell_arit ? (cell_a ^ cell_b ^ cell_cin) : cell_logic;
   assign cell_cout = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] a, b;
      logic         arit;
      logic [1:0]   s;
      logic         cin;
      logic [W-1:0] res;
      logic         c, z;
   } vec_t;

   vec_t vecs[9];

   // Issues one operation, scrambles inputs after acceptance, checks latency and outputs.
   task automatic run_op(input vec_t v);
      int n;
      @(negedge clk);
      a = v.a; b = v.b; arit = v.arit; s = v.s; c_in = v.cin; start = 1'b1;
      @(posedge clk); #1;
      check({v.name, " busy_at_accept"}, 32'(busy), 32'd1);
      start = 1'b0;
      a = ~v.a; b = ~v.b; arit = ~v.arit; s = ~v.s; c_in = ~v.cin;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      check({v.name, " latency"}, 32'(n), 32'(W));
      check({v.name, " result"}, 32'(result), 32'(v.res));
      check({v.name, " c_flag"}, 32'(c_flag), 32'(v.c));
      check({v.name, " z_flag"}, 32'(z_flag), 32'(v.z));
      @(posedge clk); #1;
      check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
      check({v.name, " result_hold"}, 32'(result), 32'(v.res));
   endtask

   initial begin
      int n, dones, gap;
      logic busy_ok;

      vecs[0] = '{"add_7_5",     4'b0111, 4'b0101, 1'b1, 2'b00, 1'b0, 4'b1100, 1'b0, 1'b0};
      vecs[1] = '{"add_f_1",     4'b1111, 4'b0001, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b1};
      vecs[2] = '{"add_3_c_ci",  4'b0011, 4'b1100, 1'b1, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1};
      vecs[3] = '{"add_0_0_ci",  4'b0000, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b0};
      vecs[4] = '{"log_and",     4'b1010, 4'b0110, 1'b0, 2'b00, 1'b0, 4'b0010, 1'b0, 1'b0};
      vecs[5] = '{"log_or",      4'b1010, 4'b0110, 1'b0, 2'b01, 1'b0, 4'b1110, 1'b0, 1'b0};
      vecs[6] = '{"log_xor",     4'b1010, 4'b0110, 1'b0, 2'b10, 1'b0, 4'b1100, 1'b0, 1'b0};
      vecs[7] = '{"log_nand",    4'b1010, 4'b0110, 1'b0, 2'b11, 1'b1, 4'b1101, 1'b0, 1'b0};
      vecs[8] = '{"log_and_zero",4'b1010, 4'b0101, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1};

      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; arit = 1'b0; s = 2'b00; c_in = 1'b0;
      #12;
      check("rst result", 32'(result), 32'd0);
      check("rst flags", {29'd0, c_flag, z_flag, busy}, 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst cell", {27'd0, cell_a, cell_b, cell_arit, cell_cin, cell_s}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i]);

      // Second start mid-RUN is ignored.
      @(negedge clk);
      a = 4'b0111; b = 4'b0101; arit = 1'b1; s = 2'b00; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      a = 4'b1111; b = 4'b1111; c_in = 1'b1; start = 1'b1;
      check("ign cell_arit", 32'(cell_arit), 32'd1);
      @(negedge clk);
      start = 1'b0;
      dones = 0; busy_ok = 1'b1; n = 0;
      while (n < 12) begin
         @(posedge clk); #1;
         n++;
         if (done) dones++;
         if (dones == 0 && !busy) busy_ok = 1'b0;
      end
      check("ign dones", 32'(dones), 32'd1);
      check("ign busy", 32'(busy_ok), 32'd1);
      check("ign result", 32'(result), 32'b1100);
      check("ign c_flag", 32'(c_flag), 32'd0);
      check("ign idle", 32'(busy), 32'd0);

      // Reset during RUN cycle 2 aborts without done.
      @(negedge clk);
      a = 4'b0011; b = 4'b0001; arit = 1'b1; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("abort result", 32'(result), 32'd0);
      check("abort flags", {29'd0, c_flag, z_flag, busy}, 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort cell", {27'd0, cell_a, cell_b, cell_arit, cell_cin, cell_s}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      check("abort no_done", 32'(dones), 32'd0);
      run_op('{"post_rst", 4'b0110, 4'b0011, 1'b1, 2'b00, 1'b0, 4'b1001, 1'b0, 1'b0});

      // Start held high: back-to-back every W+2 cycles.
      @(negedge clk);
      a = 4'b0001; b = 4'b0001; arit = 1'b1; s = 2'b00; c_in = 1'b0; start = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      check("b2b first_done", 32'(done), 32'd1);
      gap = 0;
      while (gap < 20) begin
         @(posedge clk); #1;
         gap++;
         if (done) break;
      end
      start = 1'b0;
      check("b2b period", 32'(gap), 32'(W + 2));
      check("b2b result", 32'(result), 32'b0010);
      @(posedge clk); @(posedge clk); #1;
      check("b2b drain", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that drives a single 1-bit ALU cell (the cal cell: logic cell, full adder and result mux) to perform a WIDTH-bit operation, one bit per clock, LSB first.
- Latches the operands and the operation, presents one bit pair per cycle to the cell, and registers the cell's carry between cycles.
- Shifts the cell result into a result register and reports the result with carry and zero flags.
- Sits directly upstream of the cal cell and consumes its out/c_out.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values 2..32.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- arit  in  1  1 = arithmetic (full adder), 0 = logic (cell), latched on start.
- s  in  2  logic-cell function select, latched on start.
- c_in  in  1  carry into bit 0, latched on start.
- cell_a  out  1  to cell input a.
- cell_b  out  1  to cell input b.
- cell_arit  out  1  to cell input arit.
- cell_cin  out  1  to cell input c_in.
- cell_s  out  2  to cell input s.
- cell_out  in  1  from cell out.
- cell_cout  in  1  from cell c_out.
- result  out  WIDTH  completed result.
- c_flag  out  1  final carry; 0 in logic mode.
- z_flag  out  1  1 when result == 0.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE.
  - All internal registers cleared: a_sh, b_sh, carry, cnt, result shift register.
  - result, c_flag, z_flag, busy and done are all 0.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States:
  - IDLE:
    - On start=1: a_sh<=a, b_sh<=b, op_arit<=arit, op_s<=s, carry<=c_in, cnt<=0, go to RUN.
    - start=0: remain in IDLE.
  - RUN, one bit per cycle:
    - Combinationally drive cell_a=a_sh[0], cell_b=b_sh[0], cell_cin=carry, cell_arit=op_arit, cell_s=op_s.
    - At the clock edge: shreg <= {cell_out, shreg[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry <= cell_cout; cnt <= cnt+1.
    - When cnt == WIDTH-1 at the edge: go to DONE.
    - At the same edge: result <= final shreg value; c_flag <= op_arit & cell_cout; z_flag <= (final value == 0).
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; RUN occupies cycles k+1..k+WIDTH; done=1 during cycle k+WIDTH+1. Total is WIDTH+1 cycles from accept to done.
- Outputs while idle:
  - result, c_flag and z_flag change only on the RUN→DONE edge and hold until the next completion.
  - cell_* outputs are 0 in IDLE and DONE.
- start handling:
  - start is ignored in RUN and DONE: no requeue and no effect on the running operation.
  - start held high continuously is accepted again in IDLE, giving back-to-back operations every WIDTH+2 cycles.
- Input changes on a, b, arit, s or c_in after acceptance have no effect on the running operation.
- The carry chain runs in logic mode too (the cell still produces c_out), but c_flag is forced to 0.
- cnt width is $clog2(WIDTH)+1; there is no wrap-around within one operation.

Test Plan:
- WIDTH=4, arit=1, c_in=0, a=0111, b=0101 → done at 5th cycle after accept; result=1100, c_flag=0, z_flag=0.
- a=1111, b=0001, arit=1, c_in=0 → result=0000, c_flag=1, z_flag=1.
- a=0011, b=1100, arit=1, c_in=1 → result=0000, c_flag=1, z_flag=1. Also a=0000, b=0000, c_in=1 → result=0001, c_flag=0.
- arit=0, each s in 00..11, a=1010, b=0110 → result equals the bitwise cell logic function of a,b for that s (bench golden model from the cell); c_flag=0; z_flag matches.
- Pulse start again 2 cycles into RUN with different operands → ignored; first result unchanged; exactly one done pulse; busy stays high until done.
- Assert reset_n=0 during RUN cycle 2 → all outputs 0 immediately; after release IDLE, no done; a new start completes correctly.
